// File: rtl/tms1x00_pkg.sv
// Shared definitions for the TMS1x00 program sequencer: opcode encodings,
// return-stack entry layout and the 6-bit PC LFSR step.
package tms1x00_pkg;

    localparam int PC_W   = 6;
    localparam int PAGE_W = 4;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_BR   = 3'd1,
        OP_CALL = 3'd2,
        OP_RETN = 3'd3,
        OP_LDP  = 3'd4,
        OP_COMC = 3'd5
    } op_e;

    // Chapter is always carried so the stack layout does not depend on mode.
    typedef struct packed {
        logic              chapter;
        logic [PAGE_W-1:0] page;
        logic [PC_W-1:0]   pc;
    } ret_entry_t;

    localparam int RET_W = 1 + PAGE_W + PC_W;

    // 1f and 3f are patched so the shift register covers all 64 states.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        if (pc == 6'h1f)
            return 6'h3f;
        else if (pc == 6'h3f)
            return 6'h3e;
        else
            return {pc[4:0], ~(pc[5] ^ pc[4])};
    endfunction

endpackage

// File: rtl/tms1x00_call_stack.sv
// LIFO return stack for the sequencer, 1..4 entries deep.
// Push and pop in the same cycle are never issued by the sequencer.
module tms1x00_call_stack #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [2:0]       level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [0:3];
    logic [2:0]       r_level;
    logic [1:0]       w_top;

    assign w_top = (r_level == 3'd0) ? 2'd0 : 2'(r_level - 3'd1);
    assign full  = (r_level == 3'(DEPTH));
    assign empty = (r_level == 3'd0);
    assign level = r_level;
    assign dout  = r_mem[w_top];

    // Storage carries no reset; only occupancy defines what is valid.
    always_ff @(posedge clk) begin
        if (push && !full)
            r_mem[r_level[1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_level <= 3'd0;
        else if (push && !full)
            r_level <= r_level + 3'd1;
        else if (pop && !empty)
            r_level <= r_level - 3'd1;
    end

endmodule

// File: rtl/tms1x00_sequencer.sv
// TMS1x00 program sequencer: PC, page, page buffer, chapter and return stack;
// produces the ROM fetch address and executes BR/CALL/RETN/LDP/COMC.
module tms1x00_sequencer
    import tms1x00_pkg::*;
#(
    parameter int          CHAPTER_EN  = 1,
    parameter int          STACK_DEPTH = 1,
    parameter logic [3:0]  RESET_PAGE  = 4'h0
) (
    input  logic                  clk,
    input  logic                  button_reset,
    input  logic                  step,
    input  logic                  op_valid,
    input  logic [2:0]            op_type,
    input  logic [5:0]            op_arg,
    input  logic                  status,
    output logic [9+CHAPTER_EN:0] rom_addr,
    output logic                  branch_taken,
    output logic                  in_sub,
    output logic [2:0]            stack_level,
    output logic                  stack_ovf
);

    logic [PC_W-1:0]   r_pc;
    logic [PAGE_W-1:0] r_page;
    logic [PAGE_W-1:0] r_pb;
    logic              r_chapter;
    logic              r_cb;
    logic              r_branch_taken;
    logic              r_stack_ovf;

    logic [PC_W-1:0]   w_pc_adv;
    logic [PC_W-1:0]   w_pc_d;
    logic [PAGE_W-1:0] w_page_d;
    logic [PAGE_W-1:0] w_pb_d;
    logic              w_chapter_d;
    logic              w_cb_d;
    logic              w_taken;
    logic              w_ovf_set;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    ret_entry_t        w_push_entry;
    ret_entry_t        w_top;

    // Return address is the instruction after the call when fetch advances too.
    assign w_pc_adv     = step ? pc_next(r_pc) : r_pc;
    assign w_push_entry = '{chapter: r_chapter, page: r_page, pc: w_pc_adv};

    tms1x00_call_stack #(
        .WIDTH (RET_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (button_reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_entry),
        .dout  (w_top),
        .level (stack_level),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_pc_d      = w_pc_adv;
        w_page_d    = r_page;
        w_pb_d      = r_pb;
        w_chapter_d = r_chapter;
        w_cb_d      = r_cb;
        w_taken     = 1'b0;
        w_ovf_set   = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        if (op_valid) begin
            case (op_type)
                OP_LDP: w_pb_d = op_arg[3:0];
                OP_COMC: begin
                    if (CHAPTER_EN != 0)
                        w_cb_d = ~r_cb;
                end
                OP_BR: begin
                    if (status) begin
                        w_pc_d      = op_arg;
                        w_chapter_d = r_cb;
                        w_taken     = 1'b1;
                        if (w_empty)
                            w_page_d = r_pb;
                    end
                end
                OP_CALL: begin
                    if (status) begin
                        w_pc_d      = op_arg;
                        w_chapter_d = r_cb;
                        w_taken     = 1'b1;
                        if (!w_full) begin
                            w_push   = 1'b1;
                            w_page_d = r_pb;
                            w_pb_d   = r_page;
                        end else begin
                            w_ovf_set = 1'b1;
                        end
                    end
                end
                OP_RETN: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_pc_d      = w_top.pc;
                        w_page_d    = w_top.page;
                        w_pb_d      = w_top.page;
                        w_chapter_d = w_top.chapter;
                    end else begin
                        w_page_d = r_pb;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge button_reset) begin
        if (!button_reset) begin
            r_pc           <= '0;
            r_page         <= RESET_PAGE;
            r_pb           <= RESET_PAGE;
            r_chapter      <= 1'b0;
            r_cb           <= 1'b0;
            r_branch_taken <= 1'b0;
            r_stack_ovf    <= 1'b0;
        end else begin
            r_pc           <= w_pc_d;
            r_page         <= w_page_d;
            r_pb           <= w_pb_d;
            r_chapter      <= w_chapter_d;
            r_cb           <= w_cb_d;
            r_branch_taken <= w_taken;
            r_stack_ovf    <= r_stack_ovf | w_ovf_set;
        end
    end

    generate
        if (CHAPTER_EN != 0) begin : g_chapter
            assign rom_addr = {r_chapter, r_page, r_pc};
        end else begin : g_no_chapter
            assign rom_addr = {r_page, r_pc};
        end
    endgenerate

    assign branch_taken = r_branch_taken;
    assign in_sub       = !w_empty;
    assign stack_ovf    = r_stack_ovf;

endmodule

// File: tb/tb_tms1x00_sequencer.sv
// Bench for tms1x00_sequencer: two configurations driven in lockstep and
// compared every cycle against an array-based behavioural model.
module tb_tms1x00_sequencer;
    import tms1x00_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       button_reset = 1'b1;
    logic       step = 1'b0, op_valid = 1'b0, status = 1'b0;
    logic [2:0] op_type = 3'd0;
    logic [5:0] op_arg = 6'd0;

    logic [9:0]  rom0;
    logic [10:0] rom1;
    logic        bt0, bt1, sub0, sub1, ovf0, ovf1;
    logic [2:0]  lvl0, lvl1;

    tms1x00_sequencer #(.CHAPTER_EN(0), .STACK_DEPTH(1), .RESET_PAGE(4'h0)) dut0 (
        .clk(clk), .button_reset(button_reset), .step(step), .op_valid(op_valid),
        .op_type(op_type), .op_arg(op_arg), .status(status), .rom_addr(rom0),
        .branch_taken(bt0), .in_sub(sub0), .stack_level(lvl0), .stack_ovf(ovf0));

    tms1x00_sequencer #(.CHAPTER_EN(1), .STACK_DEPTH(2), .RESET_PAGE(4'hA)) dut1 (
        .clk(clk), .button_reset(button_reset), .step(step), .op_valid(op_valid),
        .op_type(op_type), .op_arg(op_arg), .status(status), .rom_addr(rom1),
        .branch_taken(bt1), .in_sub(sub1), .stack_level(lvl1), .stack_ovf(ovf1));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Model state, index 0 = TMS1000 mode depth 1, index 1 = TMS1100 mode depth 2
    int m_pc[2], m_page[2], m_pb[2], m_ch[2], m_cb[2], m_lvl[2], m_ovf[2], m_bt[2];
    int m_sch[2][4], m_spg[2][4], m_spc[2][4];

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lfsr(input int p);
        if (p == 31) return 63;
        if (p == 63) return 62;
        return ((p << 1) & 63) | (((p >> 5) ^ (p >> 4) ^ 1) & 1);
    endfunction

    function automatic int exp_rom(input int k);
        return (m_ch[k] << 10) | (m_page[k] << 6) | m_pc[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_ch[k] = 0; m_cb[k] = 0; m_lvl[k] = 0; m_ovf[k] = 0; m_bt[k] = 0;
            m_page[k] = (k == 0) ? 0 : 10;
            m_pb[k]   = m_page[k];
        end
    endtask

    task automatic model_apply(input int k);
        int nxt, tmp, d;
        d = (k == 0) ? 1 : 2;
        m_bt[k] = 0;
        nxt = step ? lfsr(m_pc[k]) : m_pc[k];
        if (op_valid) begin
            case (op_type)
                OP_LDP:  m_pb[k] = int'(op_arg) & 15;
                OP_COMC: if (k == 1) m_cb[k] ^= 1;
                OP_BR: if (status) begin
                    nxt = int'(op_arg); m_ch[k] = m_cb[k]; m_bt[k] = 1;
                    if (m_lvl[k] == 0) m_page[k] = m_pb[k];
                end
                OP_CALL: if (status) begin
                    if (m_lvl[k] < d) begin
                        m_sch[k][m_lvl[k]] = m_ch[k];
                        m_spg[k][m_lvl[k]] = m_page[k];
                        m_spc[k][m_lvl[k]] = nxt;
                        m_lvl[k]++;
                        tmp = m_page[k]; m_page[k] = m_pb[k]; m_pb[k] = tmp;
                    end else begin
                        m_ovf[k] = 1;
                    end
                    nxt = int'(op_arg); m_ch[k] = m_cb[k]; m_bt[k] = 1;
                end
                OP_RETN: if (m_lvl[k] > 0) begin
                    m_lvl[k]--;
                    nxt = m_spc[k][m_lvl[k]];
                    m_page[k] = m_spg[k][m_lvl[k]];
                    m_pb[k] = m_page[k];
                    m_ch[k] = m_sch[k][m_lvl[k]];
                end else begin
                    m_page[k] = m_pb[k];
                end
                default: ;
            endcase
        end
        m_pc[k] = nxt;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rom_addr0", int'(rom0), exp_rom(0));
            check("rom_addr1", int'(rom1), exp_rom(1));
            check("branch_taken0", int'(bt0), m_bt[0]);
            check("branch_taken1", int'(bt1), m_bt[1]);
            check("in_sub0", int'(sub0), int'(m_lvl[0] > 0));
            check("in_sub1", int'(sub1), int'(m_lvl[1] > 0));
            check("stack_level0", int'(lvl0), m_lvl[0]);
            check("stack_level1", int'(lvl1), m_lvl[1]);
            check("stack_ovf0", int'(ovf0), m_ovf[0]);
            check("stack_ovf1", int'(ovf1), m_ovf[1]);
        end
    end

    task automatic do_cycle(input bit s, input bit v, input int t, input int a, input bit st);
        step = s; op_valid = v; op_type = 3'(t); op_arg = 6'(a); status = st;
        @(posedge clk);
        #1;
        model_apply(0);
        model_apply(1);
        #1;
    endtask

    task automatic idle();
        do_cycle(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        button_reset = 1'b0;
        model_reset();
        #1;
        check("rst_rom0", int'(rom0), 0);
        check("rst_rom1", int'(rom1), 'h280);
        check("rst_lvl1", int'(lvl1), 0);
        check("rst_ovf1", int'(ovf1), 0);
        check("rst_sub0", int'(sub0), 0);
        check("rst_bt1", int'(bt1), 0);
        @(posedge clk);
        #2;
        button_reset = 1'b1;
    endtask

    initial begin
        int seq_lit[8];
        int cnt[64];
        int p, n;
        seq_lit = '{1, 3, 7, 15, 31, 63, 62, 61};
        model_reset();
        #2;
        do_reset();
        chk_en = 1;

        // LFSR walk
        for (int j = 0; j < 64; j++) cnt[j] = 0;
        for (int i = 0; i < 64; i++) begin
            do_cycle(1, 0, 0, 0, 0);
            p = int'(rom0[5:0]);
            cnt[p]++;
            if (i < 8) check("lfsr_seq", p, seq_lit[i]);
        end
        check("lfsr_back_to_0", int'(rom0), 0);
        check("lfsr_dut1", int'(rom1), 'h280);
        n = 0;
        for (int j = 0; j < 64; j++) if (cnt[j] == 1) n++;
        check("lfsr_64_unique", n, 64);

        // LDP + BR taken / not taken
        do_cycle(0, 1, OP_LDP, 5, 0);
        do_cycle(0, 1, OP_BR, 'h12, 1);
        check("br_rom0", int'(rom0), 'h152);
        check("br_rom1", int'(rom1), 'h152);
        check("br_pulse", int'(bt0), 1);
        idle();
        check("br_pulse_end", int'(bt0), 0);
        do_cycle(0, 1, OP_BR, 'h30, 0);
        check("br_nt_rom0", int'(rom0), 'h152);
        check("br_nt_bt", int'(bt1), 0);

        // CALL / BR inside subroutine / RETN
        do_cycle(0, 1, OP_LDP, 2, 0);
        do_cycle(0, 1, OP_BR, 'h07, 1);
        check("setup_rom0", int'(rom0), 'h87);
        do_cycle(0, 1, OP_LDP, 9, 0);
        do_cycle(0, 1, OP_CALL, 'h20, 1);
        check("call_rom0", int'(rom0), 'h260);
        check("call_in_sub", int'(sub1), 1);
        do_cycle(0, 1, OP_BR, 'h30, 1);
        check("sub_br_rom0", int'(rom0), 'h270);
        do_cycle(0, 1, OP_RETN, 0, 0);
        check("retn_rom0", int'(rom0), 'h87);
        check("retn_rom1", int'(rom1), 'h87);
        check("retn_in_sub", int'(sub0), 0);

        // Nested calls and overflow
        do_cycle(0, 1, OP_LDP, 3, 0);
        do_cycle(0, 1, OP_CALL, 'h10, 1);
        do_cycle(0, 1, OP_LDP, 4, 0);
        do_cycle(0, 1, OP_CALL, 'h11, 1);
        check("ovf_d1", int'(ovf0), 1);
        check("ovf_d1_rom", int'(rom0), 'hD1);
        check("nest_rom1", int'(rom1), 'h111);
        check("nest_lvl1", int'(lvl1), 2);
        check("nest_ovf1", int'(ovf1), 0);
        do_cycle(0, 1, OP_LDP, 5, 0);
        do_cycle(0, 1, OP_CALL, 'h12, 1);
        check("ovf_d2", int'(ovf1), 1);
        check("ovf_d2_rom", int'(rom1), 'h112);
        do_cycle(0, 1, OP_RETN, 0, 0);
        do_cycle(0, 1, OP_RETN, 0, 0);
        check("unwind_rom1", int'(rom1), 'h87);
        check("unwind_rom0", int'(rom0), 'h87);
        check("unwind_lvl1", int'(lvl1), 0);
        check("ovf_sticky", int'(ovf1), 1);

        // Chapter switching
        do_cycle(0, 1, OP_COMC, 0, 0);
        do_cycle(0, 1, OP_BR, 'h00, 1);
        check("chap_bit", int'(rom1[10]), 1);
        check("chap_rom1", int'(rom1), 'h480);
        check("chap_rom0", int'(rom0), 'h080);
        do_cycle(0, 1, OP_COMC, 0, 0);
        do_cycle(0, 1, OP_CALL, 'h05, 1);
        check("chap_call_rom1", int'(rom1), 'h085);
        do_cycle(0, 1, OP_RETN, 0, 0);
        check("chap_restored", int'(rom1[10]), 1);
        check("chap_ret_rom1", int'(rom1), 'h480);

        // Reset in the middle of a subroutine
        do_cycle(0, 1, OP_LDP, 7, 0);
        do_cycle(0, 1, OP_CALL, 'h2A, 1);
        check("mid_lvl1", int'(lvl1), 1);
        check("mid_lvl0", int'(lvl0), 1);
        do_reset();

        // CALL with step: return address is the advanced PC
        do_cycle(1, 1, OP_CALL, 'h15, 1);
        check("stepcall_rom0", int'(rom0), 'h15);
        do_cycle(0, 1, OP_RETN, 0, 0);
        check("stepret_rom0", int'(rom0), 'h01);
        check("stepret_rom1", int'(rom1), 'h281);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0)
                do_reset();
            else
                do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 63)),
                         $urandom_range(0, 3) != 0);
        end
        idle();
        @(negedge clk);
        #1;
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
